// File: rtl/lfsr_blink_scheduler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : lfsr_blink_scheduler_if
// Brief    : Request / LED / grant / tick bundle of the blink scheduler.
//            The master drives requests; the slave (scheduler) drives the
//            LED, grant and tick outputs.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface lfsr_blink_scheduler_if;
  logic [3:0] i_Req;
  logic [3:0] o_LED;
  logic [3:0] o_Grant;
  logic       o_Tick;

  modport master (
    output i_Req,
    input  o_LED,
    input  o_Grant,
    input  o_Tick
  );

  modport slave (
    input  i_Req,
    output o_LED,
    output o_Grant,
    output o_Tick
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_blink_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : lfsr_blink_scheduler
// Brief    : One XNOR-LFSR timebase shared by four LED channels. Each tick
//            steps a blink sequencer (ON one tick period, OFF one tick
//            period) and the grant rotates round-robin over requesters.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module lfsr_blink_scheduler #(
  parameter int LFSR_WIDTH = 22,
  parameter int TAP_HI     = 21,
  parameter int TAP_LO     = 20
) (
  input  wire logic              i_Clk,
  input  wire logic              i_Rst,
  lfsr_blink_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  logic [LFSR_WIDTH-1:0] r_Lfsr;
  logic                  r_Tick;
  state_t                r_State;
  logic [1:0]            r_Owner;
  logic [3:0]            r_LED;
  logic [3:0]            r_Grant;

  logic                  w_Feedback;
  logic                  w_AnyReq;
  logic [1:0]            w_NextOwner;
  logic [3:0]            w_OwnerOneHot;

  // First requester after 'owner' in rotating order; the owner itself is
  // checked last so a sole requester may be re-granted.
  function automatic logic [1:0] f_search(input logic [1:0] owner,
                                          input logic [3:0] req);
    logic [1:0] res;
    logic [1:0] idx;
    res = owner;
    // Walk from the farthest offset down so the nearest hit wins.
    for (int i = 4; i >= 1; i--) begin
      idx = owner + 2'(i);
      if (req[idx]) res = idx;
    end
    return res;
  endfunction

  assign w_Feedback    = ~(r_Lfsr[TAP_HI] ^ r_Lfsr[TAP_LO]);
  assign w_AnyReq      = |bus.i_Req;
  assign w_NextOwner   = f_search(r_Owner, bus.i_Req);
  assign w_OwnerOneHot = 4'b0001 << r_Owner;

  assign bus.o_Tick  = r_Tick;
  assign bus.o_LED   = r_LED;
  assign bus.o_Grant = r_Grant;

  // Timebase: XNOR LFSR starting at zero; the tick marks each return to zero.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Lfsr <= '0;
      r_Tick <= 1'b0;
    end else begin
      r_Lfsr <= {r_Lfsr[LFSR_WIDTH-2:0], w_Feedback};
      r_Tick <= (r_Lfsr == '0);
    end
  end

  // Blink sequencer with round-robin grant; outputs follow the state by one cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State <= ST_IDLE;
      r_Owner <= 2'd3;
      r_LED   <= 4'b0000;
      r_Grant <= 4'b0000;
    end else begin
      r_LED   <= (r_State == ST_ON) ? w_OwnerOneHot : 4'b0000;
      r_Grant <= (r_State == ST_ON || r_State == ST_OFF) ? w_OwnerOneHot : 4'b0000;
      case (r_State)
        ST_IDLE: begin
          if (r_Tick && w_AnyReq) begin
            r_Owner <= w_NextOwner;
            r_State <= ST_ON;
          end
        end
        ST_ON: begin
          // A dropped request cuts the ON period short without waiting for a tick.
          if (r_Tick || !bus.i_Req[r_Owner]) begin
            r_State <= ST_OFF;
          end
        end
        ST_OFF: begin
          if (r_Tick) begin
            if (w_AnyReq) begin
              r_Owner <= w_NextOwner;
              r_State <= ST_ON;
            end else begin
              // Owner is kept so the next search resumes after it.
              r_State <= ST_IDLE;
            end
          end
        end
        default: r_State <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/lfsr_blink_scheduler.md
Name: lfsr_blink_scheduler

Overview:
- Shares one XNOR-LFSR timebase among four LED channels.
- Each LFSR terminal tick advances a blink sequencer: the granted channel's LED goes on for one tick period, then off for one tick period.
- After the off period, the grant rotates round-robin to the next requesting channel.
- Sits between the switch inputs (synchronised and debounced upstream) and the board LEDs, replacing per-LED blink counters.

Parameters:
- LFSR_WIDTH, 22, LFSR length N; tick period is 2^N-1 cycles (4194303 cycles, about 0.168 s at 25 MHz).
- TAP_HI, 21, first XNOR tap (bit index, 0-based); must be N-1.
- TAP_LO, 20, second XNOR tap (bit index); TAP_HI/TAP_LO must form a primitive 2-tap polynomial.
- Bench config: N=4, TAP_HI=3, TAP_LO=2 (x^4+x^3+1), giving period 15.

Ports:
- i_Clk  in  1  system clock; single clock domain.
- i_Rst  in  1  reset; synchronous, active-high.
- i_Req  in  4  per-channel blink request, level; bit k = channel k.
- o_LED  out  4  LED drive; at most one bit high.
- o_Grant  out  4  one-hot current owner; all zero in IDLE.
- o_Tick  out  1  one-cycle pulse at each timebase terminal.

Behaviour:
- Reset (i_Rst high at a clock edge):
  - r_Lfsr=0, o_Tick=0, state=IDLE, r_Owner=3 (so the first search starts at channel 0).
  - o_LED=0, o_Grant=0.
  - Reset mid-blink aborts immediately; all outputs are 0 the following cycle.
- LFSR, each non-reset edge:
  - r_Lfsr <= {r_Lfsr[N-2:0], r_Lfsr[TAP_HI] XNOR r_Lfsr[TAP_LO]}.
  - o_Tick <= (r_Lfsr == 0).
  - The all-ones lockup state is unreachable from 0.
  - First tick: the cycle after the first non-reset edge. Ticks then repeat every 2^N-1 cycles.
- Round-robin search:
  - Order: r_Owner+1, +2, +3, +4 (the owner itself is last), modulo 4.
  - Result: the first set bit of i_Req sampled on the tick cycle.
- States and transitions, evaluated only in cycles where o_Tick=1 unless noted:
  - IDLE: if any i_Req bit is set, r_Owner <= search result, state -> ON. Otherwise stay in IDLE.
  - ON: state -> OFF.
  - OFF: if any request, r_Owner <= search result (may be the same channel if it is the only requester), state -> ON. Otherwise state -> IDLE; r_Owner is retained for fairness.
  - Request drop, any cycle: if i_Req[r_Owner]=0 while in ON, state -> OFF next cycle, with no wait for a tick. The off period then ends at the next tick.
- Outputs, registered, one cycle after the state update:
  - o_LED = onehot(r_Owner) in ON, else 0.
  - o_Grant = onehot(r_Owner) in ON or OFF, else 0.
- Simultaneous events:
  - Request drop and tick in the same cycle in ON: go to OFF.
  - In OFF, a tick with the owner's request dropped: search skips the owner.
  - New requests arriving outside tick cycles have no effect until the next tick.
- Width rule: r_Owner is 2 bits and wraps 3 -> 0.

Test Plan:
1. Reset then i_Req=0 for 100 cycles (bench config, N=4, period 15) -> o_Tick pulses at cycles 1, 16, 31, ...; o_LED=0 and o_Grant=0 throughout.
2. i_Req=4'b0001 from reset -> o_LED=0001 for exactly 15 cycles, then 0000 for 15 cycles, repeating. o_Grant stays 0001 continuously.
3. i_Req=4'b1011 -> ON grants in order ch0, ch1, ch3, ch0, .... Each ON lasts 15 cycles and each gap lasts 15 cycles; ch2 is never granted.
4. Request ch1 alone, then drop i_Req[1] 5 cycles into ON -> o_LED=0 within 2 cycles. At the next tick, with no requesters, o_Grant goes to 0 (IDLE).
5. Assert i_Rst for one cycle while ch2 is ON -> o_LED=0, o_Grant=0 next cycle. After release, the first grant (with i_Req=4'b1111) goes to ch0.
6. Raise i_Req[2] 3 cycles after a tick while IDLE -> no LED until the next tick. o_LED=0100 appears one cycle after that tick.
